// File: rtl/core_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, instruction size
// and the alignment rule applied to redirect targets.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    TRAP  = 3'd5
  } fetch_state_e;

  localparam int         INSTR_BYTES       = 4;
  localparam logic [1:0] TARGET_ALIGN_MASK = 2'b11;

  // A redirect target is legal only when it lands on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] target_low);
    return (target_low & TARGET_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Single-entry instruction holding register between the memory response and
// decode: kill (redirect) beats load, load beats drain.
module fetch_hold_reg #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            kill,
  input  logic [ILEN-1:0] load_data,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [ILEN-1:0] data,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: issues one request at a time, holds the returned word for
// decode, and applies execute-stage redirects (flush, PC reload, stale drop).
module fetch_redirect_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            execute_done,
  input  logic            jump_signal,
  input  logic [XLEN-1:0] jump_target,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ack,
  input  logic            fetch_rvalid,
  input  logic [ILEN-1:0] fetch_rdata,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  input  logic            decode_ready,
  output logic            flush,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_pc,
  output fetch_state_e    fsm_state
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            redirect;
  logic            target_bad;
  logic            accept_rsp;
  logic            hold_valid;
  logic            hold_drain;

  // A trapped unit no longer reacts to execute; reset is its only exit.
  assign redirect   = execute_done && jump_signal && !reset && (state != TRAP);
  assign target_bad = is_misaligned(jump_target[1:0]);
  assign accept_rsp = (state == WAIT) && fetch_rvalid && !redirect;

  assign flush       = redirect;
  assign fetch_req   = (state == REQ);
  assign fetch_addr  = pc;
  assign instr_valid = hold_valid && !redirect && !reset;
  assign hold_drain  = instr_valid && decode_ready;
  assign fsm_state   = state;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect) begin
      if (target_bad) begin
        state_nxt = TRAP;
      end else begin
        pc_nxt = jump_target;
        case (state)
          // An accepted request still owes us exactly one response.
          REQ:         state_nxt = fetch_ack ? DRAIN : REQ;
          WAIT, DRAIN: state_nxt = fetch_rvalid ? REQ : DRAIN;
          default:     state_nxt = REQ;
        endcase
      end
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (fetch_ack) state_nxt = WAIT;
        end
        WAIT: begin
          if (fetch_rvalid) begin
            pc_nxt    = pc + XLEN'(INSTR_BYTES);
            state_nxt = hold_drain ? REQ : HOLD;
          end
        end
        HOLD: begin
          if (decode_ready) state_nxt = REQ;
        end
        DRAIN: begin
          if (fetch_rvalid) state_nxt = REQ;
        end
        TRAP:    state_nxt = TRAP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_trap <= 1'b0;
      trap_pc       <= '0;
    end else if (redirect && target_bad) begin
      misalign_trap <= 1'b1;
      trap_pc       <= jump_target;
    end
  end

  fetch_hold_reg #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_rsp),
    .drain     (hold_drain),
    .kill      (redirect),
    .load_data (fetch_rdata),
    .load_pc   (pc),
    .valid     (hold_valid),
    .data      (instr_out),
    .pc        (instr_pc)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: memory responder with adjustable latency,
// PC model and expected-instruction queue, directed phases then random traffic.
module tb_fetch_redirect_unit;
  import core_pkg::*;

  localparam int              XLEN    = 64;
  localparam int              ILEN    = 32;
  localparam int              W       = XLEN + ILEN;
  localparam logic [XLEN-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            execute_done = 1'b0;
  logic            jump_signal = 1'b0;
  logic [XLEN-1:0] jump_target = '0;
  logic            fetch_ack = 1'b0;
  logic            fetch_rvalid = 1'b0;
  logic [ILEN-1:0] fetch_rdata = '0;
  logic            decode_ready = 1'b0;

  logic            fetch_req, instr_valid, flush, misalign_trap;
  logic [XLEN-1:0] fetch_addr, instr_pc, trap_pc;
  logic [ILEN-1:0] instr_out;
  fetch_state_e    fsm_state;

  logic            w_fetch_req, w_instr_valid, w_flush, w_misalign_trap;
  logic [XLEN-1:0] w_fetch_addr, w_instr_pc, w_trap_pc;
  logic [ILEN-1:0] w_instr_out;
  fetch_state_e    w_fsm_state;

  fetch_redirect_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .execute_done(execute_done), .jump_signal(jump_signal),
    .jump_target(jump_target), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .decode_ready(decode_ready), .flush(flush), .misalign_trap(misalign_trap),
    .trap_pc(trap_pc), .fsm_state(fsm_state)
  );

  // Second instance starting just below the wrap point; it sees identical traffic.
  fetch_redirect_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .execute_done(execute_done), .jump_signal(jump_signal),
    .jump_target(jump_target), .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .instr_valid(w_instr_valid), .instr_out(w_instr_out), .instr_pc(w_instr_pc),
    .decode_ready(decode_ready), .flush(w_flush), .misalign_trap(w_misalign_trap),
    .trap_pc(w_trap_pc), .fsm_state(w_fsm_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_delivered = 0;

  logic [W-1:0] exp_q[$];

  int              ack_lat = 1;
  int              rv_lat = 0;
  int              req_count = 0;
  int              rv_count = 0;
  bit              outstanding = 0;
  bit              stale = 0;
  bit              trapped = 0;
  bit              wrap_phase = 0;
  bit              ovr_en = 0;
  logic [ILEN-1:0] ovr_word = '0;
  logic [XLEN-1:0] acked_addr = '0;
  logic [XLEN-1:0] model_pc = '0;
  logic [XLEN-1:0] model_trap_pc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return 32'h1300_0013 ^ a[31:0];
  endfunction

  function automatic logic [ILEN-1:0] exp_word(input logic [XLEN-1:0] a);
    return ovr_en ? ovr_word : mem_word(a);
  endfunction

  // Memory side: ack after ack_lat cycles of request, data rv_lat cycles after ack.
  task automatic respond();
    fetch_ack    = 1'b0;
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    if (reset) return;
    if (outstanding) begin
      if (rv_count >= rv_lat) begin
        fetch_rvalid = 1'b1;
        fetch_rdata  = ovr_en ? ovr_word : mem_word(acked_addr);
      end else begin
        rv_count++;
      end
    end else if (fetch_req) begin
      if (req_count >= ack_lat) begin
        fetch_ack  = 1'b1;
        acked_addr = fetch_addr;
      end else begin
        req_count++;
      end
    end
  endtask

  task automatic monitor();
    bit           redir;
    logic [W-1:0] item;
    if (reset) begin
      exp_q.delete();
      outstanding   = 0;
      stale         = 0;
      req_count     = 0;
      rv_count      = 0;
      trapped       = 0;
      model_pc      = '0;
      model_trap_pc = '0;
      return;
    end
    redir = execute_done && jump_signal && !trapped;
    check("flush", flush, redir);
    check("misalign_trap", misalign_trap, trapped);
    if (trapped) check("trap_pc", trap_pc, model_trap_pc);
    check("instr_valid", instr_valid, (exp_q.size() > 0 && !redir) ? 1 : 0);
    if (exp_q.size() > 0 || trapped) check("fetch_req_quiet", fetch_req, 0);
    if (fetch_req) check("fetch_addr", fetch_addr, model_pc);
    if (instr_valid && exp_q.size() > 0) begin
      item = exp_q[0];
      check("instr_pc", instr_pc, item[W-1:ILEN]);
      check("instr_out", instr_out, item[ILEN-1:0]);
      if (decode_ready) begin
        void'(exp_q.pop_front());
        n_delivered++;
      end
    end
    if (fetch_ack) begin
      outstanding = 1;
      stale       = 0;
      rv_count    = 0;
      req_count   = 0;
      if (wrap_phase) check("wrap_addr", w_fetch_addr, model_pc + WRAP_PC);
    end
    if (fetch_rvalid) begin
      outstanding = 0;
      if (!stale && !redir) begin
        exp_q.push_back({model_pc, exp_word(model_pc)});
        model_pc = model_pc + 64'd4;
      end
      stale = 0;
    end
    if (redir) begin
      exp_q.delete();
      if (outstanding) stale = 1;
      if (jump_target[1:0] != 2'b00) begin
        trapped       = 1;
        model_trap_pc = jump_target;
      end else begin
        model_pc = jump_target;
      end
    end
  endtask

  task automatic step(input bit rst, input bit ed, input bit js,
                      input logic [XLEN-1:0] tgt, input bit dr);
    @(posedge clk);
    #1;
    reset = rst;
    respond();
    execute_done = ed;
    jump_signal  = js;
    jump_target  = tgt;
    decode_ready = dr;
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input bit dr);
    step(1'b0, 1'b0, 1'b0, '0, dr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch_req"}, fetch_req, 0);
    check({tag, "_fetch_addr"}, fetch_addr, 64'h0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instr_out"}, instr_out, 0);
    check({tag, "_instr_pc"}, instr_pc, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_misalign_trap"}, misalign_trap, 0);
    check({tag, "_trap_pc"}, trap_pc, 0);
    check({tag, "_state"}, fsm_state, IDLE);
    check({tag, "_wrap_addr"}, w_fetch_addr, WRAP_PC);
  endtask

  initial begin
    int budget;
    int start;
    logic [XLEN-1:0] tgt;

    step(1'b1, 0, 0, '0, 0);
    step(1'b1, 0, 0, '0, 0);
    check_reset_outputs("reset");
    step(1'b0, 0, 0, '0, 0);

    // Sequential fetch from reset; wrap instance crosses 2^64.
    wrap_phase = 1;
    budget = 0;
    while (n_delivered < 3 && budget < 60) begin run(1'b1); budget++; end
    check("seq_delivered", n_delivered, 3);
    wrap_phase = 0;

    // Decode stalls with a word held.
    ovr_en = 1; ovr_word = 32'h00A0_0093;
    budget = 0;
    while (exp_q.size() == 0 && budget < 20) begin run(1'b0); budget++; end
    check("hold_loaded", exp_q.size(), 1);
    for (int i = 0; i < 5; i++) run(1'b0);
    check("hold_word", instr_out, 32'h00A0_0093);
    check("hold_valid", instr_valid, 1);
    check("hold_no_req", fetch_req, 0);
    ovr_en = 0;
    run(1'b1);

    // Redirect in WAIT, stale response follows.
    rv_lat = 3;
    budget = 0;
    while (!outstanding && budget < 20) begin run(1'b1); budget++; end
    check("wait_reached", outstanding, 1);
    step(1'b0, 1, 1, 64'h100, 1'b1);
    ovr_en = 1; ovr_word = 32'hDEAD_BEEF;
    run(1'b1);
    check("drain_state", fsm_state, DRAIN);
    budget = 0;
    while (!fetch_req && budget < 20) begin run(1'b1); budget++; end
    check("redir_addr_100", fetch_addr, 64'h100);
    ovr_en = 0; rv_lat = 0;
    start = n_delivered;
    budget = 0;
    while (n_delivered == start && budget < 20) begin run(1'b1); budget++; end
    check("deliver_after_100", n_delivered, start + 1);

    // Redirect coinciding with the response.
    budget = 0;
    while (!outstanding && budget < 20) begin run(1'b1); budget++; end
    step(1'b0, 1, 1, 64'h200, 1'b1);
    check("same_cycle_rvalid", fetch_rvalid, 1);
    run(1'b1);
    check("no_drain_state", fsm_state, REQ);
    check("redir_addr_200", fetch_addr, 64'h200);
    start = n_delivered;
    budget = 0;
    while (n_delivered == start && budget < 20) begin run(1'b1); budget++; end
    check("deliver_after_200", n_delivered, start + 1);

    // Unqualified execute signals while holding, then reset in HOLD.
    budget = 0;
    while (exp_q.size() == 0 && budget < 20) begin run(1'b0); budget++; end
    step(1'b0, 1, 0, 64'h300, 1'b0);
    step(1'b0, 0, 1, 64'h300, 1'b0);
    check("pre_reset_valid", instr_valid, 1);
    step(1'b1, 0, 0, '0, 1'b0);
    step(1'b1, 0, 0, '0, 1'b0);
    check_reset_outputs("hold_reset");
    step(1'b0, 0, 0, '0, 1'b0);

    // Random traffic with aligned redirects.
    for (int c = 0; c < 400; c++) begin
      int r;
      bit dr;
      r  = $urandom_range(0, 19);
      dr = ($urandom_range(0, 3) != 0);
      if (!outstanding && req_count == 0) ack_lat = $urandom_range(0, 2);
      if (!outstanding) rv_lat = $urandom_range(0, 2);
      tgt = XLEN'($urandom_range(0, 1023)) << 2;
      if (r == 0)      step(1'b0, 1, 1, tgt, dr);
      else if (r == 1) step(1'b0, 1, 0, tgt, dr);
      else if (r == 2) step(1'b0, 0, 1, tgt, dr);
      else             run(dr);
    end

    // Misaligned redirect traps until reset.
    step(1'b0, 1, 1, 64'h102, 1'b1);
    for (int i = 0; i < 6; i++) run(1'b1);
    check("trap_flag", misalign_trap, 1);
    check("trap_pc_val", trap_pc, 64'h102);
    check("trap_state", fsm_state, TRAP);
    check("trap_no_req", fetch_req, 0);
    step(1'b1, 0, 0, '0, 1'b0);
    step(1'b1, 0, 0, '0, 1'b0);
    check_reset_outputs("trap_reset");
    step(1'b0, 0, 0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
